// File: rtl/mem_ctrler_pkg.sv
// Shared configuration for the cache-line memory controller: line geometry,
// bus types, FSM encodings and the IO address window used when the
// MEM_CTRLER_IO_STALL_EN build option is enabled.
package mem_ctrler_pkg;

    localparam int LINE_BYTES  = 16;
    localparam int ADDR_WIDTH  = 32;
    localparam int OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int LINE_WIDTH  = 8 * LINE_BYTES;

    typedef logic [ADDR_WIDTH-1:0]             ADDR_TYPE;
    typedef logic [7:0]                        BYTE_TYPE;
    // Packed as bytes so byte i sits at [8i+7:8i] of the flat line.
    typedef logic [LINE_BYTES-1:0][7:0]        CACHE_LINE_TYPE;
    typedef logic [OFFSET_BITS-1:0]            OFFSET_TYPE;
    typedef logic [ADDR_WIDTH-OFFSET_BITS-1:0] TAG_TYPE;
    // One extra bit: a read spends LINE_BYTES+1 cycles in READ.
    typedef logic [OFFSET_BITS:0]              CNT_TYPE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Byte addresses with [17:16]==2'b11 target IO space.
    localparam int         IO_SEL_HI = 17;
    localparam int         IO_SEL_LO = 16;
    localparam logic [1:0] IO_SPACE  = 2'b11;

    localparam CNT_TYPE    CNT_ONE     = CNT_TYPE'(1);
    localparam CNT_TYPE    CNT_RD_LAST = CNT_TYPE'(LINE_BYTES);
    localparam CNT_TYPE    CNT_WR_LAST = CNT_TYPE'(LINE_BYTES - 1);
    localparam OFFSET_TYPE OFF_ONE     = OFFSET_TYPE'(1);

endpackage

// File: rtl/mem_ctrler_line_shifter.sv
// Line register for the memory controller: parallel load of a write-back
// line, byte insert for refills, and a byte-lane extract for the RAM bus.
module line_shifter
    import mem_ctrler_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  CACHE_LINE_TYPE load_line,
    input  logic           ins,
    input  OFFSET_TYPE     ins_idx,
    input  BYTE_TYPE       ins_byte,
    input  OFFSET_TYPE     ext_idx,
    output BYTE_TYPE       ext_byte,
    output CACHE_LINE_TYPE line_nxt
);

    CACHE_LINE_TYPE line;

    // Next-line view lets the owner capture a just-completed refill.
    always_comb begin
        line_nxt = line;
        if (load)
            line_nxt = load_line;
        else if (ins)
            line_nxt[ins_idx] = ins_byte;
    end

    assign ext_byte = line[ext_idx];

    // Line storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            line <= '0;
        else
            line <= line_nxt;
    end

endmodule

// File: rtl/mem_ctrler.sv
// Cache-line memory controller: serialises one full-line read (refill) or
// write (write-back) into byte accesses on the 8-bit RAM bus and returns a
// one-cycle ready pulse. Build option MEM_CTRLER_IO_STALL_EN adds the
// io_buffer_full input that holds writes into IO space.
module mem_ctrler
    import mem_ctrler_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic           valid_from_lsb,
    input  logic           rw_flag_from_lsb,
    input  ADDR_TYPE       addr_from_lsb,
    input  CACHE_LINE_TYPE cache_line_from_lsb,
    output logic           ready_to_lsb,
    output CACHE_LINE_TYPE cache_line_to_lsb,
    input  BYTE_TYPE       mem_din,
    output BYTE_TYPE       mem_dout,
    output ADDR_TYPE       mem_a,
`ifdef MEM_CTRLER_IO_STALL_EN
    input  logic           io_buffer_full,
`endif
    output logic           mem_wr
);

    state_t         state;
    CNT_TYPE        cnt;
    TAG_TYPE        tag;
    logic           ready_q;
    logic           wr_q;
    logic           io_stall;
    logic           step;
    OFFSET_TYPE     nxt_off;
    OFFSET_TYPE     ins_idx;
    BYTE_TYPE       sh_byte;
    CACHE_LINE_TYPE line_nxt;
    logic           sh_load;
    logic           sh_ins;
    logic           unused_offset;

    // The line offset of the request is ignored; base is line-aligned.
    assign unused_offset = ^addr_from_lsb[OFFSET_BITS-1:0];

`ifdef MEM_CTRLER_IO_STALL_EN
    assign io_stall = io_buffer_full && (state == WRITE) &&
                      (mem_a[IO_SEL_HI:IO_SEL_LO] == IO_SPACE);
`else
    assign io_stall = 1'b0;
`endif

    // Every register advances only on a step; a stall freezes the machine.
    assign step = rdy && !io_stall;

    // Offsets wrap within the line: no carry into the tag.
    assign nxt_off = cnt[OFFSET_BITS-1:0] + OFF_ONE;
    assign ins_idx = cnt[OFFSET_BITS-1:0] - OFF_ONE;

    assign sh_load = step && (state == IDLE) && valid_from_lsb && rw_flag_from_lsb;
    assign sh_ins  = step && (state == READ) && (cnt != '0);

    // Stalled cycles never write and never show a ready pulse.
    assign mem_wr       = wr_q && step;
    assign ready_to_lsb = ready_q && rdy;

    line_shifter u_line (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_line (cache_line_from_lsb),
        .ins       (sh_ins),
        .ins_idx   (ins_idx),
        .ins_byte  (mem_din),
        .ext_idx   (nxt_off),
        .ext_byte  (sh_byte),
        .line_nxt  (line_nxt)
    );

    // Transfer FSM with registered bus outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            cnt               <= '0;
            tag               <= '0;
            ready_q           <= 1'b0;
            wr_q              <= 1'b0;
            mem_a             <= '0;
            mem_dout          <= '0;
            cache_line_to_lsb <= '0;
        end else if (step) begin
            case (state)
                IDLE: begin
                    if (valid_from_lsb) begin
                        tag   <= addr_from_lsb[ADDR_WIDTH-1:OFFSET_BITS];
                        mem_a <= {addr_from_lsb[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        cnt   <= '0;
                        if (rw_flag_from_lsb) begin
                            state    <= WRITE;
                            wr_q     <= 1'b1;
                            mem_dout <= cache_line_from_lsb[0];
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    // Data for address n arrives while address n+1 is out.
                    if (cnt == CNT_RD_LAST) begin
                        state             <= DONE;
                        ready_q           <= 1'b1;
                        cache_line_to_lsb <= line_nxt;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt < CNT_WR_LAST)
                            mem_a <= {tag, nxt_off};
                    end
                end
                WRITE: begin
                    if (cnt == CNT_WR_LAST) begin
                        state   <= DONE;
                        ready_q <= 1'b1;
                        wr_q    <= 1'b0;
                    end else begin
                        cnt      <= cnt + CNT_ONE;
                        mem_a    <= {tag, nxt_off};
                        mem_dout <= sh_byte;
                    end
                end
                DONE: begin
                    // Request inputs are ignored here; resample in IDLE.
                    ready_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrler.sv
// Directed bench for mem_ctrler. The RAM model shares the global enable
// with the controller, so a stalled system keeps its read data in flight.
module tb_mem_ctrler;

    logic         clk = 1'b0;
    logic         rst;
    logic         rdy;
    logic         valid;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] wline;
    logic         ready;
    logic [127:0] rline;
    logic [7:0]   mem_din;
    logic [7:0]   mem_dout;
    logic [31:0]  mem_a;
    logic         mem_wr;
`ifdef MEM_CTRLER_IO_STALL_EN
    logic         io_full;
`endif

    logic         pl_we;
    logic [17:0]  pl_a;
    logic [7:0]   pl_d;
    logic [7:0]   ram [0:262143];

    int total = 0;
    int bad   = 0;
    int lat;
    logic [31:0] ra[$];
    logic [31:0] wa[$];
    logic [7:0]  wd[$];

    localparam logic [127:0] L_SEQ = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] L_WR  = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [127:0] L2    = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] L3    = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;
    localparam logic [127:0] L4    = 128'h00112233445566778899AABBCCDDEEFF;

    mem_ctrler dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .valid_from_lsb      (valid),
        .rw_flag_from_lsb    (rw),
        .addr_from_lsb       (addr),
        .cache_line_from_lsb (wline),
        .ready_to_lsb        (ready),
        .cache_line_to_lsb   (rline),
        .mem_din             (mem_din),
        .mem_dout            (mem_dout),
        .mem_a               (mem_a),
`ifdef MEM_CTRLER_IO_STALL_EN
        .io_buffer_full      (io_full),
`endif
        .mem_wr              (mem_wr)
    );

    always #5 clk = ~clk;

    // Byte RAM, one-cycle read latency, frozen with the global enable.
    always @(posedge clk) begin
        if (pl_we)
            ram[pl_a] <= pl_d;
        else if (rdy) begin
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr)
                ram[mem_a[17:0]] <= mem_dout;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, optionally stalling at cycle st_at (1 = first
    // cycle after accept), and return the accept-to-ready latency.
    task automatic run_req(input logic rw_i, input logic [31:0] a_i, input logic [127:0] l_i,
                           input int st_at, input int st_len, input logic st_io,
                           input logic keep, output int lat_o);
        logic [31:0] held;
        valid = 1'b1; rw = rw_i; addr = a_i; wline = l_i;
        tick();
        if (!keep) valid = 1'b0;
        ra.delete(); wa.delete(); wd.delete();
        lat_o = 1;
        while (!ready && lat_o < 100) begin
            if (lat_o == st_at && st_len > 0) begin
                held = mem_a;
`ifdef MEM_CTRLER_IO_STALL_EN
                if (st_io) io_full = 1'b1; else rdy = 1'b0;
`else
                rdy = 1'b0;
`endif
                for (int j = 0; j < st_len; j++) begin
                    #1;
                    chk("stall_no_wr", {127'd0, mem_wr}, 128'd0);
                    chk("stall_a_held", {96'd0, mem_a}, {96'd0, held});
                    @(posedge clk); #1;
                end
                rdy = 1'b1;
`ifdef MEM_CTRLER_IO_STALL_EN
                io_full = 1'b0;
`endif
                #1;
                lat_o += st_len;
            end
            ra.push_back(mem_a);
            if (mem_wr) begin
                wa.push_back(mem_a);
                wd.push_back(mem_dout);
            end
            tick();
            lat_o++;
        end
        chk("ready_seen", {127'd0, ready}, 128'd1);
    endtask

    task automatic check_read(input string tag, input logic [31:0] base, input logic [127:0] exp);
        chk({tag, "_line"}, rline, exp);
        chk({tag, "_nwr"}, wa.size(), 0);
        for (int n = 0; n < 16; n++)
            chk({tag, "_a"}, {96'd0, ra[n]}, {96'd0, base + n});
        tick();
        chk({tag, "_pulse"}, {127'd0, ready}, 128'd0);
    endtask

    task automatic check_write(input string tag, input logic [31:0] base, input logic [127:0] l);
        logic [127:0] lv;
        lv = l;
        chk({tag, "_nwr"}, wa.size(), 16);
        for (int n = 0; n < 16 && n < wa.size(); n++) begin
            chk({tag, "_a"}, {96'd0, wa[n]}, {96'd0, base + n});
            chk({tag, "_d"}, {120'd0, wd[n]}, {120'd0, lv[8*n +: 8]});
        end
        tick();
        chk({tag, "_pulse"}, {127'd0, ready}, 128'd0);
        chk({tag, "_wr_off"}, {127'd0, mem_wr}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; rdy = 1'b1; valid = 1'b0; rw = 1'b0; addr = '0; wline = '0;
        pl_we = 1'b0; pl_a = '0; pl_d = '0;
`ifdef MEM_CTRLER_IO_STALL_EN
        io_full = 1'b0;
`endif
        #3;
        chk("rst_ready", {127'd0, ready}, 128'd0);
        chk("rst_line", rline, 128'd0);
        chk("rst_a", {96'd0, mem_a}, 128'd0);
        chk("rst_dout", {120'd0, mem_dout}, 128'd0);
        chk("rst_wr", {127'd0, mem_wr}, 128'd0);
        #10 rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            pl_we = 1'b1; pl_a = 18'h01000 + 18'(i); pl_d = 8'(i);
            tick();
        end
        pl_we = 1'b0;
        tick();

        // Plain refill; the line offset 7 must be ignored.
        run_req(1'b0, 32'h1007, '0, 0, 0, 1'b0, 1'b0, lat);
        chk("rd_lat", lat, 18);
        check_read("rd", 32'h1000, L_SEQ);

        // Write-back then readback.
        run_req(1'b1, 32'h2000, L_WR, 0, 0, 1'b0, 1'b0, lat);
        chk("wr_lat", lat, 17);
        check_write("wr", 32'h2000, L_WR);
        run_req(1'b0, 32'h2000, '0, 0, 0, 1'b0, 1'b0, lat);
        chk("wrrb_lat", lat, 18);
        check_read("wrrb", 32'h2000, L_WR);

        // Refill-then-writeback with valid held through the ready cycle.
        run_req(1'b0, 32'h1000, '0, 0, 0, 1'b0, 1'b1, lat);
        chk("rfw_rd_lat", lat, 18);
        chk("rfw_rd_line", rline, L_SEQ);
        rw = 1'b1; addr = 32'h2400; wline = L4;
        tick();
        chk("rfw_idle_ready", {127'd0, ready}, 128'd0);
        chk("rfw_idle_wr", {127'd0, mem_wr}, 128'd0);
        run_req(1'b1, 32'h2400, L4, 0, 0, 1'b0, 1'b0, lat);
        chk("rfw_wr_lat", lat, 17);
        check_write("rfw_wr", 32'h2400, L4);
        run_req(1'b0, 32'h2400, '0, 0, 0, 1'b0, 1'b0, lat);
        check_read("rfw_rb", 32'h2400, L4);

        // Global stall of 3 cycles at READ index 5 and at WRITE index 9.
        run_req(1'b0, 32'h1000, '0, 6, 3, 1'b0, 1'b0, lat);
        chk("rdst_lat", lat, 21);
        check_read("rdst", 32'h1000, L_SEQ);
        run_req(1'b1, 32'h2800, L2, 10, 3, 1'b0, 1'b0, lat);
        chk("wrst_lat", lat, 20);
        check_write("wrst", 32'h2800, L2);
        run_req(1'b0, 32'h2800, '0, 0, 0, 1'b0, 1'b0, lat);
        check_read("wrst_rb", 32'h2800, L2);

`ifdef MEM_CTRLER_IO_STALL_EN
        // IO-space write held by a full IO buffer for 4 cycles at byte 0.
        run_req(1'b1, 32'h30000, L3, 1, 4, 1'b1, 1'b0, lat);
        chk("io_lat", lat, 21);
        check_write("io", 32'h30000, L3);
        run_req(1'b0, 32'h30000, '0, 0, 0, 1'b0, 1'b0, lat);
        check_read("io_rb", 32'h30000, L3);
`else
        run_req(1'b1, 32'h30000, L3, 0, 0, 1'b0, 1'b0, lat);
        chk("io_off_lat", lat, 17);
        check_write("io_off", 32'h30000, L3);
`endif

        // Asynchronous reset in the middle of a refill.
        valid = 1'b1; rw = 1'b0; addr = 32'h1000;
        tick();
        valid = 1'b0;
        repeat (8) tick();
        chk("mid_a", {96'd0, mem_a}, {96'd0, 32'h1008});
        #2 rst = 1'b0;
        #1;
        chk("arst_ready", {127'd0, ready}, 128'd0);
        chk("arst_line", rline, 128'd0);
        chk("arst_a", {96'd0, mem_a}, 128'd0);
        chk("arst_dout", {120'd0, mem_dout}, 128'd0);
        chk("arst_wr", {127'd0, mem_wr}, 128'd0);
        #2 rst = 1'b1;
        tick();
        run_req(1'b0, 32'h1000, '0, 0, 0, 1'b0, 1'b0, lat);
        chk("post_rst_lat", lat, 18);
        check_read("post_rst", 32'h1000, L_SEQ);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrler.md
Name: mem_ctrler

Overview:
- Responder end of the cache-line memory interface; the load/store buffer is the initiator.
- Accepts one full-line read (refill) or write (write-back) at a time.
- Serialises each line into byte accesses on the 8-bit RAM bus.
- Returns read data as one line with a single-cycle ready pulse.
- Sits between the load/store buffer and the top-level RAM/IO ports.

Parameters:
LINE_BYTES, 16, bytes per cache line (power of two); line width = 8*LINE_BYTES
ADDR_WIDTH, 32, byte-address width
OFFSET_BITS, log2(LINE_BYTES)=4, line-offset width (derived localparam)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global enable; low = freeze
valid_from_lsb  in  1  request present
rw_flag_from_lsb  in  1  0=read line, 1=write line
addr_from_lsb  in  ADDR_WIDTH  line address; low OFFSET_BITS ignored (forced 0)
cache_line_from_lsb  in  8*LINE_BYTES  write data; byte i at [8i+7:8i]
ready_to_lsb  out  1  one-cycle completion pulse
cache_line_to_lsb  out  8*LINE_BYTES  read data, valid while ready_to_lsb=1
mem_din  in  8  RAM read data; one-cycle latency after mem_a
mem_dout  out  8  RAM write data
mem_a  out  ADDR_WIDTH  RAM byte address
mem_wr  out  1  1=write this cycle

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ready_to_lsb=0, cache_line_to_lsb=0, mem_a=0, mem_dout=0, mem_wr=0; counters=0. Applies at any point, including mid-transfer.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On an edge with valid_from_lsb=1, latch base={addr[ADDR_WIDTH-1:OFFSET_BITS],0}, rw_flag and write line.
  - Go to READ (rw=0) or WRITE (rw=1). Issue index i=0.
- READ:
  - Cycle n presents mem_a=base+n, for n=0..LINE_BYTES-1.
  - mem_din sampled one cycle later is stored into byte n.
  - After LINE_BYTES+1 cycles in READ, go to DONE.
  - mem_wr=0 throughout.
- WRITE:
  - Cycle n drives mem_a=base+n, mem_dout=line byte n, mem_wr=1.
  - After LINE_BYTES cycles, go to DONE. mem_wr returns to 0 on exit.
- DONE:
  - ready_to_lsb=1 for exactly this cycle; cache_line_to_lsb holds the assembled line (read) or is unchanged (write).
  - Next state IDLE unconditionally. valid_from_lsb is ignored during DONE, so the initiator can update its request registers on the ready edge.
  - The new request is sampled in the following IDLE cycle.
- Latency, accept edge to ready cycle: read = LINE_BYTES+2 cycles (18); write = LINE_BYTES+1 cycles (17). Back-to-back turnaround: one IDLE cycle.
- cache_line_to_lsb keeps its last read value until the next read completes.
- Once accepted, a request is committed. Dropping valid mid-transfer does not abort it; ready still pulses and the initiator ignores it.
- rdy=0:
  - All registers hold and mem_wr is forced 0.
  - mem_a is held, so the byte in flight is re-read correctly on resume.
  - A ready pulse due in a stalled cycle is deferred until rdy returns.
- Address arithmetic: base+n uses the low OFFSET_BITS only; no carry into the tag/index bits and no wrap outside the line.

Optional Feature:
- Macro: MEM_CTRLER_IO_STALL_EN.
- Defined:
  - Extra input io_buffer_full (1 bit).
  - A WRITE byte whose address has [17:16]==2'b11 (IO space) stalls while io_buffer_full=1: mem_wr=0, index holds, mem_a/mem_dout held.
  - The write proceeds on the first cycle io_buffer_full=0.
- Undefined: port absent; writes never stall on IO.

Decomposition:
- Shared package/config header holds:
  - line width (LINE_BYTES, CACHE_LINE_TYPE)
  - ADDR_TYPE and BYTE_TYPE
  - state encodings (IDLE/READ/WRITE/DONE, distinct values)
  - IO address range constant
- One natural sub-module: line_shifter. It holds the line register, loads it in parallel, inserts/extracts a byte by index and presents the byte lane. The FSM and counters stay in mem_ctrler.

Test Plan:
- Read: RAM preloaded 0x1000..0x100F = 0x00..0x0F; request read addr=0x1007. Expect mem_a 0x1000..0x100F in order and ready on the 18th cycle after accept, with cache_line_to_lsb=0x0F0E..0100 (byte0 in LSBs).
- Write: line=0xFFEE..1100 to addr 0x2000. Expect 16 cycles mem_wr=1, mem_a 0x2000..0x200F, mem_dout 0x00,0x11..0xFF, then ready on cycle 17; a readback returns the same line.
- Refill-then-writeback: initiator keeps valid, flips rw_flag to 1 and changes addr on the ready edge. Expect one IDLE cycle, then a write to the new base with the new line; no stale re-read.
- Stalls: rdy low for 3 cycles at READ index 5, and separately at WRITE index 9. Expect no mem_wr during the stall, mem_a held, final line/RAM contents identical to the unstalled run, and ready delayed by exactly 3 cycles.
- Reset mid-READ at index 8: expect all outputs 0 immediately (async, no clock edge), state IDLE, and the next request completing normally.
- With MEM_CTRLER_IO_STALL_EN: write line to 0x30000 with io_buffer_full=1 for 4 cycles at byte 0. Expect mem_wr=0 for those 4 cycles, then a normal write, and ready 4 cycles later than baseline.
